// File: rtl/digit_entry_pkg.sv
// Shared definitions for the 1A2B guess path: entry states, default digit
// geometry and helpers to move between packed and per-digit views.
package digit_entry_pkg;

  localparam int DEF_NUM_DIGITS = 4;
  localparam int DEF_DIGIT_W    = 4;
  localparam int DEF_DIGIT_MAX  = 9;

  typedef enum logic {
    ST_EDIT = 1'b0,
    ST_DONE = 1'b1
  } entry_state_t;

  typedef logic [DEF_DIGIT_W-1:0] digit_t;
  typedef digit_t                 digit_arr_t [DEF_NUM_DIGITS];
  typedef logic [DEF_NUM_DIGITS*DEF_DIGIT_W-1:0] digit_vec_t;

  // Position 0 lives in the least significant digit slot.
  function automatic digit_vec_t flatten_digits(input digit_arr_t d);
    digit_vec_t v;
    v = '0;
    for (int i = 0; i < DEF_NUM_DIGITS; i++) begin
      v[i*DEF_DIGIT_W +: DEF_DIGIT_W] = d[i];
    end
    return v;
  endfunction

  function automatic digit_arr_t unflatten_digits(input digit_vec_t v);
    digit_arr_t d;
    for (int i = 0; i < DEF_NUM_DIGITS; i++) begin
      d[i] = v[i*DEF_DIGIT_W +: DEF_DIGIT_W];
    end
    return d;
  endfunction

endpackage

// File: rtl/digit_entry_dup_check.sv
// Pairwise equality check over a packed digit vector; dup is high when any
// two positions hold the same value. Purely combinational.
module digit_dup_check #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4
) (
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  output logic                          dup
);

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_DIGITS - 1; i++) begin
      for (int j = i + 1; j < NUM_DIGITS; j++) begin
        if (digits[i*DIGIT_W +: DIGIT_W] == digits[j*DIGIT_W +: DIGIT_W]) begin
          dup = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/digit_entry.sv
// Guess entry for the 1A2B game: edits an N-digit guess from key pulses and
// hands the finished guess to the scorer with a valid/ack handshake.
module digit_entry
  import digit_entry_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int DIGIT_W    = DEF_DIGIT_W,
  parameter int DIGIT_MAX  = DEF_DIGIT_MAX,
  parameter int UNIQUE     = 1,
  localparam int CUR_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          inc_key,
  input  logic                          next_key,
  input  logic                          back_key,
  input  logic                          clr_key,
  input  logic                          ack,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  output logic [CUR_W-1:0]              cursor,
  output logic                          valid,
  output logic                          dup_err,
  output logic                          editing
);

  localparam logic [CUR_W-1:0]   LAST_POS  = CUR_W'(NUM_DIGITS - 1);
  localparam logic [DIGIT_W-1:0] TOP_DIGIT = DIGIT_W'(DIGIT_MAX);

  entry_state_t                  state_q, state_d;
  logic [NUM_DIGITS*DIGIT_W-1:0] digits_q, digits_d;
  logic [CUR_W-1:0]              cursor_q, cursor_d;
  logic                          valid_q, dup_err_q, dup_err_d, editing_q;
  logic                          dup;

  digit_dup_check #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIGIT_W    (DIGIT_W)
  ) u_dup_check (
    .digits (digits_q),
    .dup    (dup)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d   = state_q;
    digits_d  = digits_q;
    cursor_d  = cursor_q;
    dup_err_d = 1'b0;

    unique case (state_q)
      ST_EDIT: begin
        if (clr_key) begin
          digits_d = '0;
          cursor_d = '0;
        end else if (back_key) begin
          if (cursor_q != '0) cursor_d = cursor_q - CUR_W'(1);
        end else if (next_key) begin
          if (cursor_q != LAST_POS) begin
            cursor_d = cursor_q + CUR_W'(1);
          end else if (UNIQUE != 0 && dup) begin
            dup_err_d = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else if (inc_key) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cursor_q == CUR_W'(i)) begin
              digits_d[i*DIGIT_W +: DIGIT_W] =
                (digits_q[i*DIGIT_W +: DIGIT_W] == TOP_DIGIT) ? '0
                : digits_q[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
            end
          end
        end
      end
      ST_DONE: begin
        // Abandon and acknowledge are deliberately the same transition.
        if (ack || clr_key) begin
          state_d  = ST_EDIT;
          digits_d = '0;
          cursor_d = '0;
        end
      end
      default: state_d = ST_EDIT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EDIT;
      digits_q  <= '0;
      cursor_q  <= '0;
      valid_q   <= 1'b0;
      dup_err_q <= 1'b0;
      editing_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      cursor_q  <= cursor_d;
      valid_q   <= (state_d == ST_DONE);
      dup_err_q <= dup_err_d;
      editing_q <= (state_d == ST_EDIT);
    end
  end

  assign digits  = digits_q;
  assign cursor  = cursor_q;
  assign valid   = valid_q;
  assign dup_err = dup_err_q;
  assign editing = editing_q;

endmodule

// File: tb/tb_digit_entry.sv
// Bench for digit_entry: a default 4-digit unique instance and a 6-digit,
// max-5, non-unique instance, both checked against a per-key reference model.
module tb_digit_entry;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic inc0 = 0, next0 = 0, back0 = 0, clr0 = 0, ack0 = 0;
  logic inc1 = 0, next1 = 0, back1 = 0, clr1 = 0, ack1 = 0;

  logic [15:0] digits0;
  logic [1:0]  cursor0;
  logic        valid0, dup0, edit0;
  logic [23:0] digits1;
  logic [2:0]  cursor1;
  logic        valid1, dup1, edit1;

  digit_entry u_dut0 (
    .clk(clk), .rst_n(rst_n), .inc_key(inc0), .next_key(next0),
    .back_key(back0), .clr_key(clr0), .ack(ack0), .digits(digits0),
    .cursor(cursor0), .valid(valid0), .dup_err(dup0), .editing(edit0)
  );

  digit_entry #(.NUM_DIGITS(6), .DIGIT_W(4), .DIGIT_MAX(5), .UNIQUE(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .inc_key(inc1), .next_key(next1),
    .back_key(back1), .clr_key(clr1), .ack(ack1), .digits(digits1),
    .cursor(cursor1), .valid(valid1), .dup_err(dup1), .editing(edit1)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: guess as an integer array, cursor as an integer, a flag
  // for "guess submitted", and the one-cycle reject flag.
  int n_dig [2] = '{4, 6};
  int d_max [2] = '{9, 5};
  bit uniq  [2] = '{1'b1, 1'b0};
  int m_dig [2][6];
  int m_cur [2];
  bit m_done[2];
  bit m_dup [2];

  function automatic bit has_repeat(input int k);
    int seen [16];
    for (int v = 0; v < 16; v++) seen[v] = 0;
    for (int i = 0; i < n_dig[k]; i++) seen[m_dig[k][i]]++;
    for (int v = 0; v < 16; v++) if (seen[v] > 1) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset(input int k);
    for (int i = 0; i < 6; i++) m_dig[k][i] = 0;
    m_cur[k]  = 0;
    m_done[k] = 1'b0;
    m_dup[k]  = 1'b0;
  endtask

  task automatic model_step(input int k, input bit c, input bit b, input bit n,
                            input bit i, input bit a);
    m_dup[k] = 1'b0;
    if (m_done[k]) begin
      if (a || c) model_reset(k);
    end else if (c) begin
      model_reset(k);
    end else if (b) begin
      if (m_cur[k] > 0) m_cur[k]--;
    end else if (n) begin
      if (m_cur[k] < n_dig[k] - 1) m_cur[k]++;
      else if (uniq[k] && has_repeat(k)) m_dup[k] = 1'b1;
      else m_done[k] = 1'b1;
    end else if (i) begin
      m_dig[k][m_cur[k]] = (m_dig[k][m_cur[k]] + 1) % (d_max[k] + 1);
    end
  endtask

  task automatic cmp(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check(input int k, input string tag);
    logic [23:0] e_dig, o_dig;
    logic [23:0] o_cur;
    logic        o_val, o_dup, o_ed;
    e_dig = '0;
    for (int i = 0; i < n_dig[k]; i++) e_dig = e_dig | (24'(m_dig[k][i]) << (4 * i));
    if (k == 0) begin
      o_dig = {8'h0, digits0}; o_cur = 24'(cursor0);
      o_val = valid0; o_dup = dup0; o_ed = edit0;
    end else begin
      o_dig = digits1; o_cur = 24'(cursor1);
      o_val = valid1; o_dup = dup1; o_ed = edit1;
    end
    cmp({tag, ".digits"},  o_dig, e_dig);
    cmp({tag, ".cursor"},  o_cur, 24'(m_cur[k]));
    cmp({tag, ".valid"},   24'(o_val), 24'(m_done[k]));
    cmp({tag, ".dup_err"}, 24'(o_dup), 24'(m_dup[k]));
    cmp({tag, ".editing"}, 24'(o_ed), 24'(!m_done[k]));
  endtask

  // One cycle of keys on instance k; the other instance sees no keys.
  task automatic press(input int k, input bit c, input bit b, input bit n,
                       input bit i, input bit a, input string tag);
    @(negedge clk);
    if (k == 0) begin clr0 = c; back0 = b; next0 = n; inc0 = i; ack0 = a; end
    else        begin clr1 = c; back1 = b; next1 = n; inc1 = i; ack1 = a; end
    @(posedge clk);
    #1;
    {clr0, back0, next0, inc0, ack0} = '0;
    {clr1, back1, next1, inc1, ack1} = '0;
    model_step(k, c, b, n, i, a);
    model_step(1 - k, 0, 0, 0, 0, 0);
    check(k, tag);
  endtask

  task automatic inc_n(input int k, input int cnt, input string tag);
    for (int j = 0; j < cnt; j++) press(k, 0, 0, 0, 1, 0, tag);
  endtask

  task automatic nxt(input int k, input string tag);
    press(k, 0, 0, 1, 0, 0, tag);
  endtask

  task automatic idle(input string tag);
    press(0, 0, 0, 0, 0, 0, tag);
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    #12;
    check(0, "reset0");
    check(1, "reset1");
    @(negedge clk);
    rst_n = 1'b1;

    // Build 1,2,3,4 and submit, then acknowledge.
    for (int d = 1; d <= 4; d++) begin
      inc_n(0, d, "t1.inc");
      nxt(0, "t1.next");
    end
    cmp("t1.digits_4321", {8'h0, digits0}, 24'h004321);
    idle("t1.hold");
    press(0, 0, 0, 0, 0, 1, "t1.ack");

    // Wrap after the largest digit.
    inc_n(0, 10, "t2.wrap10");
    cmp("t2.digit0_after10", {20'h0, digits0[3:0]}, 24'h0);
    press(0, 1, 0, 0, 0, 0, "t2.clr");
    inc_n(0, 11, "t2.wrap11");
    press(0, 1, 0, 0, 0, 0, "t2.clr2");

    // Duplicate rejection, then repair and submit.
    inc_n(0, 1, "t3.e"); nxt(0, "t3.n");
    inc_n(0, 1, "t3.e"); nxt(0, "t3.n");
    inc_n(0, 2, "t3.e"); nxt(0, "t3.n");
    inc_n(0, 3, "t3.e");
    nxt(0, "t3.dup");
    cmp("t3.dup_seen", 24'(dup0), 24'h1);
    idle("t3.dup_drop");
    press(0, 0, 1, 0, 0, 0, "t3.back");
    press(0, 0, 1, 0, 0, 0, "t3.back");
    inc_n(0, 1, "t3.fix1"); nxt(0, "t3.n");
    inc_n(0, 2, "t3.fix2"); nxt(0, "t3.n");
    nxt(0, "t3.submit");
    cmp("t3.digits_3421", {8'h0, digits0}, 24'h003421);

    // In DONE inc/next/back are ignored; clr abandons.
    press(0, 0, 0, 0, 1, 0, "t5.inc_ign");
    press(0, 0, 0, 1, 0, 0, "t5.next_ign");
    press(0, 0, 1, 0, 0, 0, "t5.back_ign");
    press(0, 1, 0, 0, 0, 1, "t5.clr_ack");

    // Back at cursor 0, then key priority at cursor 2.
    inc_n(0, 3, "t4.e");
    press(0, 0, 1, 0, 0, 0, "t4.back_at0");
    nxt(0, "t4.n"); nxt(0, "t4.n");
    press(0, 0, 1, 1, 1, 0, "t4.prio");
    cmp("t4.cursor1", 24'(cursor0), 24'h1);
    press(0, 1, 1, 1, 1, 0, "t4.clr_prio");

    // Asynchronous reset mid-entry: cursor 2, digits 0x0057.
    inc_n(0, 7, "t6.e"); nxt(0, "t6.n");
    inc_n(0, 5, "t6.e"); nxt(0, "t6.n");
    cmp("t6.pre_digits", {8'h0, digits0}, 24'h000057);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    check(0, "t6.async");
    @(negedge clk);
    rst_n = 1'b1;

    // Six-digit, non-unique instance accepts 3,3,3,3,3,3.
    for (int p = 0; p < 6; p++) begin
      inc_n(1, 3, "t6b.e");
      nxt(1, "t6b.n");
    end
    cmp("t6b.valid", 24'(valid1), 24'h1);
    press(1, 0, 0, 0, 0, 1, "t6b.ack");

    // Random key traffic on both instances; keys are sparse so guesses finish.
    for (int r = 0; r < 600; r++) begin
      int k;
      int roll;
      bit c, b, n, i, a;
      k = r % 2;
      roll = $urandom_range(0, 99);
      c = (roll < 3);
      b = ($urandom_range(0, 99) < 12);
      n = ($urandom_range(0, 99) < 30);
      i = ($urandom_range(0, 99) < 50);
      a = ($urandom_range(0, 99) < 25);
      press(k, c, b, n, i, a, (k == 0) ? "rnd0" : "rnd1");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
